mmd_param: RTL



---
 rtl/mmd_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/mmd_param.sv
// Multi-modulus divider: divides CKV by a runtime modulus with a one-deep,
// valid/ready modulus buffer. Build option MMD_CLAMP_EN clamps illegal moduli to DIV_MIN.
module mmd_param #(
  parameter int unsigned W       = 7,
  parameter int unsigned DIV_MIN = 2,
  parameter int unsigned DIV_RST = 32
) (
  input  logic         CKV,
  input  logic         NARST,
  input  logic [W-1:0] DIVNUM,
  input  logic         DIV_VLD,
  output logic         DIV_RDY,
  input  logic         ERR_CLR,
  output logic         CKVD,
  output logic         CKVD_PULSE,
  output logic [W-1:0] PHASE,
  output logic         DIV_ERR
);

  localparam logic [W-1:0] DIV_MIN_W = W'(DIV_MIN);
  localparam logic [W-1:0] DIV_RST_W = W'(DIV_RST);
  localparam logic [W-1:0] ONE_W     = W'(1);
  localparam logic [W-1:0] TWO_W     = W'(2);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_cur_q, div_cur_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         ckvd_q, ckvd_d;
  logic         ckvd_pulse_q, ckvd_pulse_d;
  logic         div_err_q, div_err_d;

  logic         wrap;
  logic         accept;
  logic         illegal;
  logic         acc_use;
  logic [W-1:0] acc_val;

  always_comb begin
    wrap    = (cnt_q == div_cur_q - ONE_W);
    accept  = DIV_VLD && !pend_vld_q;
    illegal = (DIVNUM < DIV_MIN_W) || (DIVNUM < TWO_W);
`ifdef MMD_CLAMP_EN
    acc_val = illegal ? DIV_MIN_W : DIVNUM;
    acc_use = accept;
`else
    acc_val = DIVNUM;
    acc_use = accept && !illegal;
`endif
  end

  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + ONE_W;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    // At a wrap the buffered modulus wins; an empty buffer lets a same-cycle accept bypass it.
    if (wrap) begin
      if (pend_vld_q) begin
        div_cur_d  = pend_q;
        pend_vld_d = 1'b0;
      end else if (acc_use) begin
        div_cur_d = acc_val;
      end
    end else if (acc_use) begin
      pend_d     = acc_val;
      pend_vld_d = 1'b1;
    end

    ckvd_d       = (cnt_q >= (div_cur_q >> 1));
    ckvd_pulse_d = wrap;

    if (accept && illegal) begin
      div_err_d = 1'b1;
    end else if (ERR_CLR) begin
      div_err_d = 1'b0;
    end else begin
      div_err_d = div_err_q;
    end
  end

  always_ff @(posedge CKV or negedge NARST) begin
    if (!NARST) begin
      cnt_q        <= '0;
      div_cur_q    <= DIV_RST_W;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      ckvd_q       <= 1'b0;
      ckvd_pulse_q <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_cur_q    <= div_cur_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      ckvd_q       <= ckvd_d;
      ckvd_pulse_q <= ckvd_pulse_d;
      div_err_q    <= div_err_d;
    end
  end

  assign DIV_RDY    = !pend_vld_q;
  assign CKVD       = ckvd_q;
  assign CKVD_PULSE = ckvd_pulse_q;
  assign PHASE      = cnt_q;
  assign DIV_ERR    = div_err_q;

endmodule
